// File: rtl/dbg_probe.sv
// Debug read-burst probe: walks a word range in the CPU register file or data
// memory through the CPU debug ports and streams each word out with its address.
module dbg_probe #(
  parameter int DmAddrBits = 10,
  parameter int DmLatency  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_space,
  input  logic [DmAddrBits-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  output logic [4:0]            dbg_rf_req,
  output logic [DmAddrBits-1:0] dbg_dm_addr,
  input  logic [31:0]           dbg_rf_data,
  input  logic [31:0]           dbg_dm_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [DmAddrBits-1:0] rsp_addr,
  output logic                  rsp_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_e;

  localparam bit         DmHasWait  = (DmLatency != 0);
  localparam logic [1:0] DmWaitLast = 2'(DmLatency - 1);

  state_e                state_q, state_d;
  logic                  space_q, space_d;
  logic [DmAddrBits-1:0] addr_q, addr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            wait_q, wait_d;
  logic [4:0]            rf_req_q, rf_req_d;
  logic [DmAddrBits-1:0] dm_addr_q, dm_addr_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic [DmAddrBits-1:0] rsp_addr_q, rsp_addr_d;
  logic                  rsp_last_q, rsp_last_d;

  logic [DmAddrBits-1:0] next_addr;
  logic [4:0]            rf_next;

  // RF addresses live zero-extended in addr_q so they can go straight to rsp_addr.
  assign rf_next   = addr_q[4:0] + 5'd1;
  assign next_addr = space_q ? addr_q + 1'b1 : {{(DmAddrBits-5){1'b0}}, rf_next};

  always_comb begin
    state_d    = state_q;
    space_d    = space_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    rf_req_d   = rf_req_q;
    dm_addr_d  = dm_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_addr_d = rsp_addr_q;
    rsp_last_d = rsp_last_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          space_d = cmd_space;
          cnt_d   = cmd_len;
          if (cmd_space) begin
            addr_d    = cmd_addr;
            dm_addr_d = cmd_addr;
          end else begin
            addr_d   = {{(DmAddrBits-5){1'b0}}, cmd_addr[4:0]};
            rf_req_d = cmd_addr[4:0];
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (space_q && DmHasWait) begin
          wait_d  = DmWaitLast;
          state_d = WAIT;
        end else begin
          rsp_data_d = space_q ? dbg_dm_data : dbg_rf_data;
          rsp_addr_d = addr_q;
          rsp_last_d = (cnt_q == 8'd0);
          state_d    = OUT;
        end
      end

      WAIT: begin
        if (wait_q == 2'd0) begin
          rsp_data_d = dbg_dm_data;
          rsp_addr_d = addr_q;
          rsp_last_d = (cnt_q == 8'd0);
          state_d    = OUT;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end

      OUT: begin
        if (rsp_ready) begin
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_q - 8'd1;
            addr_d = next_addr;
            if (space_q) dm_addr_d = next_addr;
            else         rf_req_d  = rf_next;
            state_d = ISSUE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      space_q    <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      rf_req_q   <= '0;
      dm_addr_q  <= '0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
      rsp_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      space_q    <= space_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      rf_req_q   <= rf_req_d;
      dm_addr_q  <= dm_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_last_q <= rsp_last_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = (state_q == OUT);
  assign rsp_data    = rsp_data_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_last    = rsp_last_q;
  assign dbg_rf_req  = rf_req_q;
  assign dbg_dm_addr = dm_addr_q;

endmodule

// File: tb/tb_dbg_probe.sv
// Self-checking bench for dbg_probe: models the CPU debug ports and predicts
// each burst as a plain list of (address, data, last) words.
module tb_dbg_probe;

  localparam int AddrBits = 10;
  localparam int DmLat    = 1;
  localparam int DmWords  = 1 << AddrBits;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_space;
  logic [AddrBits-1:0] cmd_addr;
  logic [7:0]          cmd_len;
  logic [4:0]          dbg_rf_req;
  logic [AddrBits-1:0] dbg_dm_addr;
  logic [31:0]         dbg_rf_data;
  logic [31:0]         dbg_dm_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic [AddrBits-1:0] rsp_addr;
  logic                rsp_last;
  logic                busy;

  logic [31:0] regs [32];
  logic [31:0] mem  [DmWords];

  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  // CPU side: RF reads are combinational, DM reads have one cycle of latency.
  assign dbg_rf_data = regs[dbg_rf_req];
  always @(posedge clk) dbg_dm_data <= mem[dbg_dm_addr];

  dbg_probe #(
    .DmAddrBits(AddrBits),
    .DmLatency (DmLat)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_space  (cmd_space),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .dbg_rf_req (dbg_rf_req),
    .dbg_dm_addr(dbg_dm_addr),
    .dbg_rf_data(dbg_rf_data),
    .dbg_dm_data(dbg_dm_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_addr   (rsp_addr),
    .rsp_last   (rsp_last),
    .busy       (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Called at a negedge with the block idle; returns at a negedge, idle again.
  task automatic applyStimulus(input bit space, input int addr, input int len,
                               input int stallWord, input int stallCycles,
                               input bit randStall, input bit pokeCmd);
    logic [31:0] expData[$];
    int          expAddr[$];
    int          lat;
    int          waited;
    int          stall;
    logic [31:0] otherDbg;
    lat = space ? DmLat : 0;
    for (int i = 0; i <= len; i++) begin
      int a;
      a = space ? (addr + i) % DmWords : (addr + i) % 32;
      expAddr.push_back(a);
      expData.push_back(space ? mem[a] : regs[a]);
    end
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    otherDbg  = space ? 32'(dbg_rf_req) : 32'(dbg_dm_addr);
    cmd_valid = 1'b1;
    cmd_space = space;
    cmd_addr  = AddrBits'(addr);
    cmd_len   = 8'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_space = 1'($urandom);
    cmd_addr  = AddrBits'($urandom);
    for (int i = 0; i <= len; i++) begin
      waited = 0;
      while (!rsp_valid && waited < 16) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("rsp_latency", waited, lat + 1);
      if (!rsp_valid) return;
      checkOutput("rsp_data", rsp_data, expData[i]);
      checkOutput("rsp_addr", rsp_addr, expAddr[i]);
      checkOutput("rsp_last", rsp_last, (i == len) ? 1 : 0);
      checkOutput("ready_busy_in_out", {cmd_ready, busy}, 2'b01);
      stall = (i == stallWord) ? stallCycles : (randStall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < stall; s++) begin
        rsp_ready = 1'b0;
        if (pokeCmd) begin
          cmd_valid = 1'b1;
          cmd_space = 1'($urandom);
          cmd_addr  = AddrBits'($urandom);
          cmd_len   = 8'($urandom);
        end
        @(negedge clk);
        checkOutput("stall_valid", rsp_valid, 1);
        checkOutput("stall_data", rsp_data, expData[i]);
        checkOutput("stall_addr", rsp_addr, expAddr[i]);
        checkOutput("stall_last", rsp_last, (i == len) ? 1 : 0);
        checkOutput("stall_dbg_addr", space ? 32'(dbg_dm_addr) : 32'(dbg_rf_req), expAddr[i]);
        checkOutput("stall_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
    end
    checkOutput("idle_after_burst", {cmd_ready, busy, rsp_valid}, 3'b100);
    checkOutput("other_dbg_held", space ? 32'(dbg_rf_req) : 32'(dbg_dm_addr), otherDbg);
    repeat (3) @(negedge clk);
    checkOutput("no_extra_burst", {busy, rsp_valid}, 2'b00);
  endtask

  initial begin
    int waited;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_space = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < DmWords; i++) mem[i] = 32'(i * 4);
    regs[7] = 32'hDEADBEEF;

    repeat (2) @(negedge clk);
    checkOutput("reset_ready_busy_valid", {cmd_ready, busy, rsp_valid, rsp_last}, 4'b1000);
    checkOutput("reset_rsp_data", rsp_data, 0);
    checkOutput("reset_rsp_addr", rsp_addr, 0);
    checkOutput("reset_dbg_addrs", {dbg_rf_req, dbg_dm_addr}, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] RF single read");
    applyStimulus(1'b0, 7, 0, -1, 0, 1'b0, 1'b0);
    $display("[TB] DM wrapping burst");
    applyStimulus(1'b1, 'h3FE, 3, -1, 0, 1'b0, 1'b0);
    $display("[TB] Backpressure with ignored commands");
    applyStimulus(1'b1, 'h10, 3, 1, 5, 1'b0, 1'b1);
    applyStimulus(1'b0, 5, 2, 1, 5, 1'b0, 1'b1);
    $display("[TB] RF wrap");
    applyStimulus(1'b0, 30, 3, -1, 0, 1'b0, 1'b0);
    $display("[TB] Full-length bursts");
    applyStimulus(1'b1, 'h380, 255, -1, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 17, 255, -1, 0, 1'b1, 1'b0);

    $display("[TB] Reset mid-burst");
    cmd_valid = 1'b1;
    cmd_space = 1'b1;
    cmd_addr  = AddrBits'(100);
    cmd_len   = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rst_first_word_data", rsp_data, mem[100]);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_wait", {busy, rsp_valid}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_abort_state", {cmd_ready, busy, rsp_valid, rsp_last}, 4'b1000);
    checkOutput("rst_abort_data", rsp_data, 0);
    checkOutput("rst_abort_dm_addr", dbg_dm_addr, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 7, 1, -1, 0, 1'b0, 1'b0);

    $display("[TB] Randomized bursts");
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < DmWords; i++) mem[i] = $urandom;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom), int'($urandom_range(0, DmWords - 1)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dbg_probe.md
DBG_PROBE -- requirements
Module: dbg_probe

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter: DmAddrBits, default 10, width of the CPU debug data-memory word address.
REQ-003 Parameter: DmLatency, default 1, legal range 0..3, cycles from dbg_dm_addr stable to dbg_dm_data valid.
REQ-004 clk  in  1  rising-edge clock, same clock as the CPU debug ports.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 cmd_valid  in  1  read-burst request present.
REQ-007 cmd_ready  out  1  block accepts a request this cycle.
REQ-008 cmd_space  in  1  0 = register file, 1 = data memory.
REQ-009 cmd_addr  in  DmAddrBits  start word address; RF space uses bits [4:0] only.
REQ-010 cmd_len  in  8  burst length minus one, giving 1..256 words.
REQ-011 dbg_rf_req  out  5  RF debug read index, to CPU.
REQ-012 dbg_dm_addr  out  DmAddrBits  DM debug word address, to CPU.
REQ-013 dbg_rf_data  in  32  RF debug read data, valid in the same cycle as the index.
REQ-014 dbg_dm_data  in  32  DM debug read data, valid DmLatency cycles after the address.
REQ-015 rsp_valid  out  1  response word present.
REQ-016 rsp_ready  in  1  consumer accepts the response word.
REQ-017 rsp_data  out  32  captured word.
REQ-018 rsp_addr  out  DmAddrBits  address of rsp_data; zero-extended for RF.
REQ-019 rsp_last  out  1  final word of the burst.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The state machine SHALL have states IDLE, ISSUE, WAIT, OUT.
REQ-022 cmd_ready SHALL equal (state==IDLE); on the handshake edge the block SHALL latch space, addr and len into internal registers and enter ISSUE.
REQ-023 In ISSUE the block SHALL drive the current address on the dbg port of the selected space, and SHALL hold it unchanged through WAIT until capture.
REQ-024 The effective latency L SHALL be 0 for RF and DmLatency for DM; from ISSUE the block SHALL go to OUT when L=0, and otherwise to WAIT for exactly L cycles.
REQ-025 The block SHALL capture the selected dbg data into rsp_data on the edge leaving the last ISSUE/WAIT cycle, and SHALL assert rsp_valid in the next cycle; rsp_valid SHALL rise L+2 cycles after the cmd handshake cycle.
REQ-026 In OUT, rsp_data, rsp_addr and rsp_last SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-027 rsp_last SHALL be 1 when the remaining count is 0.
REQ-028 On the OUT handshake: if rsp_last=1, the block SHALL enter IDLE; otherwise it SHALL decrement the count, increment the address and enter ISSUE.
REQ-029 Sustained throughput SHALL be one word per L+2 cycles with rsp_ready held high.
REQ-030 The address increment SHALL wrap modulo 32 for RF (31->0) and modulo 2^DmAddrBits for DM.
REQ-031 The address outputs of the unselected space SHALL hold their last values.
REQ-032 In IDLE, dbg_rf_req and dbg_dm_addr SHALL hold their last driven values.
REQ-033 cmd_valid SHALL be ignored in every state other than IDLE; no request queueing.
REQ-034 A cmd_len of 255 SHALL read 256 words, and the address SHALL wrap where needed.

Reset
REQ-035 While rst=1 the block SHALL set state=IDLE, cmd_ready=1, rsp_valid=0, rsp_last=0, busy=0, and rsp_data, rsp_addr, dbg_rf_req, dbg_dm_addr and the count to 0.
REQ-036 A reset asserted mid-burst SHALL abort the burst with no further response; the first cycle after reset SHALL accept a new command.

Verification
REQ-037 RF single read: regs[7]=0xDEADBEEF; cmd space=0 addr=7 len=0 at cycle 0 -> rsp_valid at cycle 2, data 0xDEADBEEF, addr 7, last=1; cmd_ready=1 after the handshake.
REQ-038 DM burst, DmLatency=1: mem[i]=i*4; addr=0x3FE len=3 -> words 0x3FE, 0x3FF, 0x000, 0x001 in order, data i*4, last only on the 4th; one word every 3 cycles with rsp_ready held high.
REQ-039 Backpressure: hold rsp_ready=0 for 5 cycles on the 2nd word -> rsp_* stable, dbg address unchanged, no word lost or duplicated.
REQ-040 RF wrap: addr=30 len=3 -> rsp_addr sequence 30, 31, 0, 1.
REQ-041 Reset during WAIT of the 2nd DM word -> rsp_valid=0 and busy=0 next cycle; a new RF command is then served correctly.
REQ-042 cmd_valid pulsed during OUT -> ignored; cmd_ready=0 until the burst completes.
